// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: commit record type, default FIFO depth and popcount helper.
// The record carries a cycle stamp only when COMMIT_TRACE_TIMESTAMP_EN is defined.
package commit_trace_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 16;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
        logic [4:0]          reg_addr;
        logic [XLEN_DEF-1:0] reg_data;
        logic [XLEN_DEF-1:0] mem_addr;
        logic [XLEN_DEF-1:0] mem_data;
        logic                mem_wrt;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [31:0]         cycle;
`endif
    } commit_rec_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/commit_compact.sv
// commit_compact: packs the active commit lanes, in ascending lane order, into
// the lowest record slots and reports how many lanes are active.
module commit_compact
    import commit_trace_pkg::*;
#(
    parameter int IssueWidth = 2,
    parameter int XLEN       = XLEN_DEF
) (
    input  logic [IssueWidth-1:0]                     update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]           pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]           instr_i,
    input  logic [IssueWidth-1:0][4:0]                reg_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]           reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]           mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]           mem_data_i,
    input  logic [IssueWidth-1:0]                     mem_wrt_i,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    input  logic [31:0]                               cycle_i,
`endif
    output commit_rec_t [IssueWidth-1:0]              recs_o,
    output logic [$clog2(IssueWidth+1)-1:0]           n_o
);

    localparam int NW = $clog2(IssueWidth + 1);
    localparam int IB = $clog2(IssueWidth);

    logic [NW-1:0] k;

    assign n_o = NW'(popcount(32'(update_i)));

    // k is the next free slot; it only advances on active lanes
    always_comb begin
        recs_o = '0;
        k      = '0;
        for (int l = 0; l < IssueWidth; l++) begin
            if (update_i[l]) begin
                recs_o[k[IB-1:0]].pc       = pc_i[l];
                recs_o[k[IB-1:0]].instr    = instr_i[l];
                recs_o[k[IB-1:0]].reg_addr = reg_addr_i[l];
                recs_o[k[IB-1:0]].reg_data = reg_data_i[l];
                recs_o[k[IB-1:0]].mem_addr = mem_addr_i[l];
                recs_o[k[IB-1:0]].mem_data = mem_data_i[l];
                recs_o[k[IB-1:0]].mem_wrt  = mem_wrt_i[l];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
                recs_o[k[IB-1:0]].cycle    = cycle_i;
`endif
                k = k + NW'(1);
            end
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: compacting circular FIFO of retired-instruction records with
// a valid/ready drain port and retire/drop counters; COMMIT_TRACE_TIMESTAMP_EN adds trace_cycle_o.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int IssueWidth = 2,
    parameter int XLEN       = XLEN_DEF,
    parameter int Depth      = DEPTH_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [IssueWidth-1:0]           update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0] pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0] instr_i,
    input  logic [IssueWidth-1:0][4:0]      reg_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0] reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0] mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0] mem_data_i,
    input  logic [IssueWidth-1:0]           mem_wrt_i,
    output logic                            stall_o,
    output logic                            trace_valid_o,
    input  logic                            trace_ready_i,
    output logic [XLEN-1:0]                 trace_pc_o,
    output logic [XLEN-1:0]                 trace_instr_o,
    output logic [4:0]                      trace_reg_addr_o,
    output logic [XLEN-1:0]                 trace_reg_data_o,
    output logic [XLEN-1:0]                 trace_mem_addr_o,
    output logic [XLEN-1:0]                 trace_mem_data_o,
    output logic                            trace_mem_wrt_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    output logic [31:0]                     trace_cycle_o,
`endif
    output logic [63:0]                     retired_cnt_o,
    output logic [31:0]                     drop_cnt_o,
    output logic                            overflow_o
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(IssueWidth + 1);

    commit_rec_t [IssueWidth-1:0] recs;
    commit_rec_t                  mem_q [Depth];
    commit_rec_t                  head;
    logic [NW-1:0]                n;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d, free, n_ext;
    logic [63:0]                  retired_q, retired_d;
    logic [31:0]                  drop_q, drop_d;
    logic                         overflow_q, overflow_d;
    logic                         push, drop, pop;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cyc_q <= '0;
        else       cyc_q <= cyc_q + 32'd1;
    end
`endif

    commit_compact #(
        .IssueWidth (IssueWidth),
        .XLEN       (XLEN)
    ) u_compact (
        .update_i   (update_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_wrt_i  (mem_wrt_i),
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        .cycle_i    (cyc_q),
`endif
        .recs_o     (recs),
        .n_o        (n)
    );

    // free space uses the pre-pop count so stall never depends on trace_ready_i
    assign n_ext = CW'(n);
    assign free  = CW'(Depth) - count_q;
    assign push  = (n != '0) && (free >= n_ext);
    assign drop  = (n != '0) && (free < n_ext);
    assign pop   = (count_q != '0) && trace_ready_i;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(n) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + (push ? n_ext : '0) - CW'(pop);
        retired_d  = push ? retired_q + 64'(n) : retired_q;
        drop_d     = (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            retired_q  <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            retired_q  <= retired_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (push) begin
            for (int s = 0; s < IssueWidth; s++)
                if (NW'(s) < n) mem_q[wr_ptr_q + PW'(s)] <= recs[s];
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign trace_valid_o    = count_q != '0;
    assign stall_o          = free < CW'(IssueWidth);
    assign trace_pc_o       = head.pc;
    assign trace_instr_o    = head.instr;
    assign trace_reg_addr_o = head.reg_addr;
    assign trace_reg_data_o = head.reg_data;
    assign trace_mem_addr_o = head.mem_addr;
    assign trace_mem_data_o = head.mem_data;
    assign trace_mem_wrt_o  = head.mem_wrt;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    assign trace_cycle_o    = head.cycle;
`endif
    assign retired_cnt_o    = retired_q;
    assign drop_cnt_o       = drop_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed and random stimulus checked against a queue-based model.
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc, instr, reg_data, mem_addr, mem_data;
        logic [4:0]  reg_addr;
        logic        mem_wrt;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [1:0]      update_i = '0;
    logic [1:0][31:0] pc_i = '0, instr_i = '0, reg_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
    logic [1:0][4:0] reg_addr_i = '0;
    logic [1:0]      mem_wrt_i = '0;
    logic            trace_ready_i = 1'b0;
    logic            stall_o, trace_valid_o, trace_mem_wrt_o, overflow_o;
    logic [31:0]     trace_pc_o, trace_instr_o, trace_reg_data_o, trace_mem_addr_o, trace_mem_data_o;
    logic [4:0]      trace_reg_addr_o;
    logic [63:0]     retired_cnt_o;
    logic [31:0]     drop_cnt_o;

    rec_t        q[$];
    logic [63:0] m_ret;
    logic [31:0] m_drop;
    logic        m_ovf;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.IssueWidth(2), .XLEN(32), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
        .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i), .stall_o(stall_o),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
        .trace_instr_o(trace_instr_o), .trace_reg_data_o(trace_reg_data_o),
        .trace_mem_addr_o(trace_mem_addr_o), .trace_mem_data_o(trace_mem_data_o),
        .trace_reg_addr_o(trace_reg_addr_o), .trace_mem_wrt_o(trace_mem_wrt_o),
        .retired_cnt_o(retired_cnt_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input logic [1:0] upd);
        update_i = upd;
        for (int l = 0; l < 2; l++) begin
            pc_i[l]       = $urandom;
            instr_i[l]    = $urandom;
            reg_addr_i[l] = 5'($urandom);
            reg_data_i[l] = $urandom;
            mem_addr_i[l] = $urandom;
            mem_data_i[l] = $urandom;
            mem_wrt_i[l]  = 1'($urandom);
        end
    endtask

    // whole groups are accepted only if they fit in the space left before this cycle's pop
    task automatic model_step();
        int n;
        bit acc;
        if (rst_i) begin
            q.delete();
            m_ret = '0; m_drop = '0; m_ovf = 1'b0;
        end else begin
            n = $countones(update_i);
            acc = (n > 0) && ((DEPTH - q.size()) >= n);
            if (n > 0 && !acc) begin
                if (m_drop != 32'hFFFF_FFFF) m_drop++;
                m_ovf = 1'b1;
            end
            if (q.size() != 0 && trace_ready_i) void'(q.pop_front());
            if (acc) begin
                for (int l = 0; l < 2; l++)
                    if (update_i[l])
                        q.push_back('{pc: pc_i[l], instr: instr_i[l], reg_data: reg_data_i[l],
                                      mem_addr: mem_addr_i[l], mem_data: mem_data_i[l],
                                      reg_addr: reg_addr_i[l], mem_wrt: mem_wrt_i[l]});
                m_ret += 64'(n);
            end
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(trace_valid_o), 64'(q.size() != 0));
        chk("stall", 64'(stall_o), 64'((DEPTH - q.size()) < 2));
        chk("retired", retired_cnt_o, m_ret);
        chk("drops", 64'(drop_cnt_o), 64'(m_drop));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        if (q.size() != 0) begin
            chk("head_pc", 64'(trace_pc_o), 64'(q[0].pc));
            chk("head_instr", 64'(trace_instr_o), 64'(q[0].instr));
            chk("head_rd", 64'(trace_reg_addr_o), 64'(q[0].reg_addr));
            chk("head_rdata", 64'(trace_reg_data_o), 64'(q[0].reg_data));
            chk("head_maddr", 64'(trace_mem_addr_o), 64'(q[0].mem_addr));
            chk("head_mdata", 64'(trace_mem_data_o), 64'(q[0].mem_data));
            chk("head_mwrt", 64'(trace_mem_wrt_o), 64'(q[0].mem_wrt));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic zero_fields(input string tag);
        chk({tag, "_pc0"}, 64'(trace_pc_o), 64'd0);
        chk({tag, "_data0"}, 64'(trace_reg_data_o ^ trace_mem_addr_o ^ trace_mem_data_o ^ trace_instr_o), 64'd0);
        chk({tag, "_misc0"}, 64'({trace_reg_addr_o, trace_mem_wrt_o}), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        set_lanes(2'b11);
        trace_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        set_lanes(2'b00);
        tick();
        zero_fields("reset");

        set_lanes(2'b11);
        pc_i[0] = 32'h8000_0000;
        pc_i[1] = 32'h8000_0004;
        trace_ready_i = 1'b1;
        tick();
        chk("pair_first", 64'(trace_pc_o), 64'h8000_0000);
        set_lanes(2'b00);
        tick();
        chk("pair_second", 64'(trace_pc_o), 64'h8000_0004);
        chk("pair_retired", retired_cnt_o, 64'd2);
        tick();

        set_lanes(2'b10);
        pc_i[1] = 32'h8000_0010;
        trace_ready_i = 1'b0;
        tick();
        chk("compact_pc", 64'(trace_pc_o), 64'h8000_0010);
        set_lanes(2'b00);
        trace_ready_i = 1'b1;
        tick();
        chk("compact_single", 64'(trace_valid_o), 64'd0);

        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_lanes(2'b11);
            tick();
        end
        chk("full_stall", 64'(stall_o), 64'd1);
        set_lanes(2'b11);
        tick();
        chk("drop_cnt", 64'(drop_cnt_o), 64'd1);
        chk("drop_ovf", 64'(overflow_o), 64'd1);
        chk("drop_retired", retired_cnt_o, 64'd19);

        set_lanes(2'b11);
        trace_ready_i = 1'b1;
        tick();
        chk("full_pop_drop", 64'(drop_cnt_o), 64'd2);
        chk("full_pop_retired", retired_cnt_o, 64'd19);

        set_lanes(2'b00);
        for (int i = 0; i < 15; i++) tick();
        chk("drained", 64'(trace_valid_o), 64'd0);

        for (int i = 0; i < 20; i++) begin
            set_lanes(i % 2 ? 2'b10 : 2'b01);
            trace_ready_i = (i % 2 == 0);
            tick();
        end
        set_lanes(2'b00);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("wrap_retired", retired_cnt_o, 64'd39);

        for (int i = 0; i < 400; i++) begin
            set_lanes(2'($urandom));
            trace_ready_i = ($urandom_range(0, 9) < 4);
            tick();
        end

        set_lanes(2'b00);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        trace_ready_i = 1'b0;
        set_lanes(2'b11); tick();
        set_lanes(2'b11); tick();
        set_lanes(2'b01); tick();
        chk("pre_reset_ovf", 64'(overflow_o), 64'd1);
        rst_i = 1'b1;
        set_lanes(2'b11);
        trace_ready_i = 1'b1;
        tick();
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_counters", {retired_cnt_o[31:0], drop_cnt_o}, 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        zero_fields("midreset");
        rst_i = 1'b0;
        set_lanes(2'b00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
